mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Sits in EX beside the combinational ALU, with a valid/ready handshake so the pipeline stalls while an operation is in flight.
- Generalised in data width; signed and unsigned modes.
- Multi-cycle: one quotient/product bit per clock.

Parameters:
- NB_DATA, 32, operand / HI / LO width; must be even and >= 4.
- NB_OP, 6, funct field width.
- NB_CNT, $clog2(NB_DATA+1), iteration counter width (derived; do not override).

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  request present on i_funct / operands.
- i_funct  in  NB_OP  operation code.
- i_datoA  in  NB_DATA  rs operand (multiplicand / dividend / MT source).
- i_datoB  in  NB_DATA  rt operand (multiplier / divisor).
- i_flush  in  1  synchronous abort of the in-flight operation.
- o_ready  out  1  unit idle, request accepted this cycle when i_valid=1.
- o_done  out  1  one-cycle pulse: HI/LO just updated by MULT*/DIV*.
- o_data  out  NB_DATA  MFHI/MFLO read data.
- o_hi  out  NB_DATA  HI register.
- o_lo  out  NB_DATA  LO register.

Behaviour:
- Funct codes:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- Reset (async, i_rst_n=0):
  - State IDLE; HI=LO=0; counter=0.
  - o_done=0, o_ready=1, o_data=0.
  - Reset mid-operation discards all work.
- States: IDLE, RUN, FIX.
- Accept = i_valid & o_ready & ~i_flush. o_ready=1 only in IDLE.
- IDLE, accept of MTHI/MTLO:
  - HI/LO <= i_datoA at the accept edge.
  - Stay IDLE; no o_done.
- IDLE, MFHI/MFLO:
  - o_data = HI/LO combinationally while in IDLE.
  - Otherwise o_data = 0.
  - No state change.
- IDLE, accept of MULT*/DIV*:
  - Latch operands.
  - Signed ops: latch magnitudes, plus result-sign flags.
  - Counter <= NB_DATA; go RUN.
- RUN:
  - Multiply: shift-add into a 2*NB_DATA accumulator, one bit per cycle.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Counter decrements every cycle; at counter==1 go FIX.
  - RUN lasts exactly NB_DATA cycles.
- FIX, one cycle, then IDLE at the exit edge:
  - Apply two's-complement correction.
    - Product sign = A^B.
    - Quotient sign = A^B; remainder sign = sign of A.
  - Write HI/LO.
  - o_done registered high in the following cycle, together with o_ready=1.
- Latency: o_done high exactly NB_DATA+2 clock edges after the accept edge.
- Back-to-back: a new request may be accepted in the o_done cycle.
- Results:
  - MULT/MULTU: {HI,LO} = full 2*NB_DATA product.
  - DIV/DIVU: LO = quotient (truncated toward zero), HI = remainder.
- Divide by zero, detected at accept:
  - Still takes full latency.
  - LO = all ones, HI = i_datoA unchanged.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0. No exception.
- i_flush:
  - In RUN/FIX: return to IDLE next edge.
  - HI/LO unchanged; no o_done.
  - In IDLE: flush wins over i_valid, nothing accepted.
- Unknown funct with valid in IDLE: accepted as no-op; no state change.
- MF*/MT* while busy: not accepted (o_ready=0); upstream holds the request.

Decomposition:
- Package mdu_pkg:
  - Funct localparams.
  - State encoding (IDLE=2'd0, RUN=2'd1, FIX=2'd2).
  - Helper for NB_CNT.
- One sub-module: mdu_div_step. Combinational restoring-divide step: partial remainder, divisor -> next remainder, quotient bit.
- Multiplier step stays inline.

Test Plan (NB_DATA=32):
- MULT A=-3, B=7 -> HI=FFFFFFFF, LO=FFFFFFEB.
  - o_done exactly 34 edges after accept.
  - o_ready low for 33 cycles.
- MULTU A=FFFFFFFF, B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
  - Back-to-back DIVU FFFFFFFF/10 issued in the o_done cycle -> LO=0FFFFFFF, HI=0000000F.
- DIV A=-7, B=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIV A=80000000, B=FFFFFFFF -> LO=80000000, HI=0.
- DIVU A=1234, B=0 -> LO=FFFFFFFF, HI=00001234.
- MTHI A=CAFEF00D then MFHI -> o_data=CAFEF00D.
  - Start MULT, pulse i_flush at RUN cycle 10 -> IDLE next edge, no o_done, HI still CAFEF00D.
  - Assert i_rst_n=0 mid-RUN -> HI=LO=0 immediately, o_ready=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes,
// FSM state encoding and the iteration-counter width helper.
package mdu_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Counter must hold the value NB_DATA itself, hence the +1.
  function automatic int cnt_bits(input int nb);
    return $clog2(nb + 1);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module mdu_div_step #(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] i_rem,
  input  logic               i_bit,
  input  logic [NB_DATA-1:0] i_divisor,
  output logic [NB_DATA-1:0] o_rem,
  output logic               o_qbit
);

  logic [NB_DATA:0] shifted;
  logic [NB_DATA:0] diff;

  // Trial subtraction; a clear borrow bit means the divisor fits.
  always_comb begin
    shifted = {i_rem, i_bit};
    diff    = shifted - {1'b0, i_divisor};
    o_qbit  = ~diff[NB_DATA];
    o_rem   = o_qbit ? diff[NB_DATA-1:0] : shifted[NB_DATA-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers. One product or
// quotient bit per clock; signed ops run on magnitudes and are sign-fixed
// in a final correction cycle.
//
// state | meaning
// IDLE  | ready; MT*/MF* served, MULT*/DIV* accepted
// RUN   | NB_DATA shift-add / shift-subtract iterations
// FIX   | sign correction, HI/LO write, then back to IDLE
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [NB_OP-1:0]   i_funct,
  input  logic [NB_DATA-1:0] i_datoA,
  input  logic [NB_DATA-1:0] i_datoB,
  input  logic               i_flush,
  output logic               o_ready,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam int NB_CNT = cnt_bits(NB_DATA);

  state_e                  state_q, state_d;
  logic [NB_CNT-1:0]       cnt_q, cnt_d;
  logic [2*NB_DATA-1:0]    acc_q, acc_d;
  logic [NB_DATA-1:0]      b_q, b_d;
  logic [NB_DATA-1:0]      a_q, a_d;
  logic [NB_DATA-1:0]      hi_q, hi_d;
  logic [NB_DATA-1:0]      lo_q, lo_d;
  logic                    is_div_q, is_div_d;
  logic                    neg_res_q, neg_res_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    dz_q, dz_d;
  logic                    done_q, done_d;

  logic                    fn_mthi, fn_mtlo, fn_mfhi, fn_mflo;
  logic                    fn_mul, fn_div, fn_signed, accept;
  logic                    sign_a, sign_b;
  logic [NB_DATA-1:0]      mag_a, mag_b;
  logic [NB_DATA:0]        mul_sum;
  logic [2*NB_DATA-1:0]    mul_acc, div_acc, prod;
  logic [NB_DATA-1:0]      div_rem, quo_fix, rem_fix;
  logic                    div_qbit;

  mdu_div_step #(.NB_DATA(NB_DATA)) u_div_step (
    .i_rem     (acc_q[2*NB_DATA-1:NB_DATA]),
    .i_bit     (acc_q[NB_DATA-1]),
    .i_divisor (b_q),
    .o_rem     (div_rem),
    .o_qbit    (div_qbit)
  );

  // Decode, datapath steps and result correction.
  always_comb begin
    fn_mthi   = (i_funct == NB_OP'(FN_MTHI));
    fn_mtlo   = (i_funct == NB_OP'(FN_MTLO));
    fn_mfhi   = (i_funct == NB_OP'(FN_MFHI));
    fn_mflo   = (i_funct == NB_OP'(FN_MFLO));
    fn_mul    = (i_funct == NB_OP'(FN_MULT)) | (i_funct == NB_OP'(FN_MULTU));
    fn_div    = (i_funct == NB_OP'(FN_DIV))  | (i_funct == NB_OP'(FN_DIVU));
    fn_signed = (i_funct == NB_OP'(FN_MULT)) | (i_funct == NB_OP'(FN_DIV));
    accept    = i_valid & (state_q == ST_IDLE) & ~i_flush;
    sign_a    = fn_signed & i_datoA[NB_DATA-1];
    sign_b    = fn_signed & i_datoB[NB_DATA-1];
    mag_a     = sign_a ? (~i_datoA + 1'b1) : i_datoA;
    mag_b     = sign_b ? (~i_datoB + 1'b1) : i_datoB;
    mul_sum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + {1'b0, (acc_q[0] ? b_q : '0)};
    mul_acc   = {mul_sum, acc_q[NB_DATA-1:1]};
    div_acc   = {div_rem, acc_q[NB_DATA-2:0], div_qbit};
    prod      = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix   = neg_res_q ? (~acc_q[NB_DATA-1:0] + 1'b1) : acc_q[NB_DATA-1:0];
    rem_fix   = neg_rem_q ? (~acc_q[2*NB_DATA-1:NB_DATA] + 1'b1)
                          : acc_q[2*NB_DATA-1:NB_DATA];
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (fn_mthi) hi_d = i_datoA;
          if (fn_mtlo) lo_d = i_datoA;
          if (fn_mul | fn_div) begin
            a_d       = i_datoA;
            is_div_d  = fn_div;
            neg_res_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            dz_d      = fn_div & (i_datoB == '0);
            b_d       = fn_div ? mag_b : mag_a;
            acc_d     = {{NB_DATA{1'b0}}, (fn_div ? mag_a : mag_b)};
            cnt_d     = NB_CNT'(NB_DATA);
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = is_div_q ? div_acc : mul_acc;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == NB_CNT'(1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!i_flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[2*NB_DATA-1:NB_DATA];
            lo_d = prod[NB_DATA-1:0];
          end else if (dz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight work.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  // MF* read port is live only while idle with a request present.
  always_comb begin
    o_data = '0;
    if ((state_q == ST_IDLE) && i_valid) begin
      if (fn_mfhi)      o_data = hi_q;
      else if (fn_mflo) o_data = lo_q;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_done  = done_q;
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at NB_DATA=32: reset, MT/MF, multiply and
// divide results, latency, back-to-back issue, flush and mid-run reset.
module tb_mdu_iter;

  localparam int N = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk;
  logic         rst_n;
  logic         valid;
  logic [5:0]   funct;
  logic [N-1:0] da, db;
  logic         flush;
  logic         ready, done;
  logic [N-1:0] data, hi, lo;

  int tests = 0;
  int fails = 0;

  mdu_iter #(.NB_DATA(N), .NB_OP(6)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_funct (funct),
    .i_datoA (da),
    .i_datoB (db),
    .i_flush (flush),
    .o_ready (ready),
    .o_done  (done),
    .o_data  (data),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request, let one edge take it, then withdraw it.
  task automatic issue(input logic [5:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    valid = 1'b1; funct = f; da = a; db = b;
    @(posedge clk); #1;
    valid = 1'b0; funct = 6'd0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (done) begin timed_out = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; funct = 6'd0; da = '0; db = '0; flush = 1'b0;
    #12;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    tests++; if (data !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", data); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult_latency();
    int edges, low;
    edges = 1; low = 0;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL mult_ready_pre got %b want 1", ready); end
    issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
    if (!ready) low++;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
      if (!ready) low++;
    end
    tests++; if (edges !== 34) begin fails++; $display("FAIL mult_latency got %0d want 34", edges); end
    tests++; if (low !== 33) begin fails++; $display("FAIL mult_busy_cycles got %0d want 33", low); end
    tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    tests++; if (lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL mult_ready_done got %b want 1", ready); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    bit to;
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(to);
    tests++; if (to) begin fails++; $display("FAIL multu_timeout got timeout want done"); end
    tests++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin fails++; $display("FAIL multu_result got %h want fffffffe00000001", {hi, lo}); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", ready); end
    issue(F_DIVU, 32'hFFFF_FFFF, 32'h10);
    tests++; if ({done, ready} !== 2'b00) begin fails++; $display("FAIL b2b_accept got done,ready=%b want 00", {done, ready}); end
    wait_done(to);
    tests++; if (to) begin fails++; $display("FAIL divu_timeout got timeout want done"); end
    tests++; if (lo !== 32'h0FFF_FFFF) begin fails++; $display("FAIL divu_lo got %h want 0fffffff", lo); end
    tests++; if (hi !== 32'h0000_000F) begin fails++; $display("FAIL divu_hi got %h want 0000000f", hi); end
  endtask

  task automatic test_div();
    bit to;
    logic [5:0]   vf [5];
    logic [N-1:0] va [5], vb [5], vlo [5], vhi [5];
    vf[0] = F_DIV;  va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;        vlo[0] = 32'hFFFF_FFFD; vhi[0] = 32'hFFFF_FFFF;
    vf[1] = F_DIV;  va[1] = 32'h8000_0000; vb[1] = 32'hFFFF_FFFF; vlo[1] = 32'h8000_0000; vhi[1] = 32'h0;
    vf[2] = F_DIVU; va[2] = 32'h0000_1234; vb[2] = 32'h0;        vlo[2] = 32'hFFFF_FFFF; vhi[2] = 32'h0000_1234;
    vf[3] = F_DIV;  va[3] = 32'hFFFF_FFF9; vb[3] = 32'h0;        vlo[3] = 32'hFFFF_FFFF; vhi[3] = 32'hFFFF_FFF9;
    vf[4] = F_DIV;  va[4] = 32'd100;       vb[4] = 32'hFFFF_FFF9; vlo[4] = 32'hFFFF_FFF2; vhi[4] = 32'd2;
    for (int k = 0; k < 5; k++) begin
      issue(vf[k], va[k], vb[k]);
      wait_done(to);
      tests++; if (to) begin fails++; $display("FAIL div%0d_timeout got timeout want done", k); end
      tests++; if ({hi, lo} !== {vhi[k], vlo[k]}) begin
        fails++; $display("FAIL div%0d_result got hi=%h lo=%h want hi=%h lo=%h", k, hi, lo, vhi[k], vlo[k]);
      end
    end
  endtask

  task automatic test_mt_mf();
    issue(F_MTLO, 32'h1234_5678, 32'h0);
    issue(F_MTHI, 32'hCAFE_F00D, 32'h0);
    tests++; if ({ready, done} !== 2'b10) begin fails++; $display("FAIL mthi_state got ready,done=%b want 10", {ready, done}); end
    tests++; if (hi !== 32'hCAFE_F00D) begin fails++; $display("FAIL mthi_hi got %h want cafef00d", hi); end
    valid = 1'b1; funct = F_MFHI; #1;
    tests++; if (data !== 32'hCAFE_F00D) begin fails++; $display("FAIL mfhi_data got %h want cafef00d", data); end
    funct = F_MFLO; #1;
    tests++; if (data !== 32'h1234_5678) begin fails++; $display("FAIL mflo_data got %h want 12345678", data); end
    valid = 1'b0; #1;
    tests++; if (data !== 32'h0) begin fails++; $display("FAIL mf_idle_data got %h want 0", data); end
    issue(6'b111111, 32'hDEAD_BEEF, 32'h1);
    tests++; if ({ready, hi, lo} !== {1'b1, 32'hCAFE_F00D, 32'h1234_5678}) begin
      fails++; $display("FAIL unknown_noop got ready=%b hi=%h lo=%h want 1 cafef00d 12345678", ready, hi, lo);
    end
  endtask

  task automatic test_flush();
    int seen;
    flush = 1'b1;
    issue(F_MTHI, 32'h0BAD_0BAD, 32'h0);
    flush = 1'b0;
    tests++; if (hi !== 32'hCAFE_F00D) begin fails++; $display("FAIL idle_flush_hi got %h want cafef00d", hi); end
    issue(F_MULT, 32'd5, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL flush_busy got %b want 0", ready); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++; if ({ready, done} !== 2'b10) begin fails++; $display("FAIL flush_idle got ready,done=%b want 10", {ready, done}); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL flush_no_done got %0d pulses want 0", seen); end
    tests++; if (hi !== 32'hCAFE_F00D) begin fails++; $display("FAIL flush_hi got %h want cafef00d", hi); end
  endtask

  task automatic test_reset_mid_run();
    issue(F_MULT, 32'd3, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL rst_run_hilo got %h want 0", {hi, lo}); end
    tests++; if ({ready, done} !== 2'b10) begin fails++; $display("FAIL rst_run_state got ready,done=%b want 10", {ready, done}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL rst_run_discard got %h want 0", {hi, lo}); end
  endtask

  initial begin
    test_reset();
    test_mult_latency();
    test_back_to_back();
    test_div();
    test_mt_mf();
    test_flush();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
